fp_sum_accumulator: RTL and testbench

Streaming IEEE-754-style floating-point accumulator that sits directly downstream of `floating_point_mul` (and the exponential stage) in the softmax datapath. It consumes one product or exponential term per handshake, adds it to a running sum with a multi-cycle align/add/normalize sequence, and emits the total when the term flagged `in_last` has been added. The sum feeds the softmax normalization divider.

---
 rtl/fp_sum_accumulator.sv | 168 ++++++++++++++++
 tb/tb_fp_sum_accumulator.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/fp_sum_accumulator.sv
// Streaming floating-point accumulator for the softmax datapath: sums one term per
// handshake through ALIGN/ADD/NORM and presents the total after the last term.
module fp_sum_accumulator #(
    parameter int DATA_WIDTH = 32,
    parameter int M          = 23,
    parameter int E          = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int MW = M + 2;
    localparam logic [E-1:0] EXP_ONE = {{(E-1){1'b0}}, 1'b1};
    localparam logic [E-1:0] EXP_MAX = {{(E-1){1'b1}}, 1'b0};

    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;

    state_t state, next_state;

    logic                  acc_sign;
    logic [E-1:0]          acc_exp;
    logic [MW-1:0]         acc_man;
    logic                  acc_zero;
    logic [DATA_WIDTH-1:0] op_data;
    logic                  op_last;
    logic [MW-1:0]         op_man;

    logic          op_sign;
    logic [E-1:0]  op_exp;
    logic [MW-1:0] op_full;
    logic          op_is_zero;
    logic          acc_ge;
    logic [E-1:0]  exp_diff;
    state_t        exit_state;

    assign op_sign    = op_data[DATA_WIDTH-1];
    assign op_exp     = op_data[DATA_WIDTH-2:M];
    assign op_full    = {2'b01, op_data[M-1:0]};
    assign op_is_zero = ~|op_data[DATA_WIDTH-2:0];
    assign acc_ge     = acc_exp >= op_exp;
    assign exp_diff   = acc_ge ? (acc_exp - op_exp) : (op_exp - acc_exp);
    assign exit_state = op_last ? DONE : IDLE;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out_data  = acc_zero ? '0 : {acc_sign, acc_exp, acc_man[M-1:0]};

    // Truncating alignment shift; anything shifted past the mantissa width is gone.
    function automatic logic [MW-1:0] shr(input logic [MW-1:0] v, input logic [E-1:0] d);
        logic [MW-1:0] r;
        if (int'(d) >= MW) r = '0;
        else               r = v >> d;
        return r;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (in_valid) next_state = ALIGN;
            ALIGN: next_state = (op_is_zero || acc_zero) ? exit_state : ADD;
            ADD:   next_state = NORM;
            NORM: begin
                if (acc_man == '0 || acc_man[M+1] || acc_man[M] || acc_exp <= EXP_ONE)
                    next_state = exit_state;
            end
            DONE:  if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_sign <= 1'b0;
            acc_exp  <= '0;
            acc_man  <= '0;
            acc_zero <= 1'b1;
            op_data  <= '0;
            op_last  <= 1'b0;
            op_man   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_data <= in_data;
                        op_last <= in_last;
                    end
                end
                ALIGN: begin
                    if (op_is_zero) begin
                        acc_zero <= acc_zero;
                    end else if (acc_zero) begin
                        acc_sign <= op_sign;
                        acc_exp  <= op_exp;
                        acc_man  <= op_full;
                        acc_zero <= 1'b0;
                    end else if (acc_ge) begin
                        op_man <= shr(op_full, exp_diff);
                    end else begin
                        acc_man <= shr(acc_man, exp_diff);
                        acc_exp <= op_exp;
                        op_man  <= op_full;
                    end
                end
                ADD: begin
                    if (acc_sign == op_sign) begin
                        acc_man <= acc_man + op_man;
                    end else if (acc_man > op_man) begin
                        acc_man <= acc_man - op_man;
                    end else if (op_man > acc_man) begin
                        acc_man  <= op_man - acc_man;
                        acc_sign <= op_sign;
                    end else begin
                        acc_man  <= '0;
                        acc_sign <= 1'b0;
                    end
                end
                NORM: begin
                    // Exact cancellation and exponent underflow both collapse to zero.
                    if (acc_man == '0) begin
                        acc_zero <= 1'b1;
                        acc_sign <= 1'b0;
                        acc_exp  <= '0;
                    end else if (acc_man[M+1]) begin
                        if (acc_exp >= EXP_MAX) begin
                            acc_exp <= EXP_MAX;
                            acc_man <= {2'b01, {M{1'b1}}};
                        end else begin
                            acc_exp <= acc_exp + EXP_ONE;
                            acc_man <= acc_man >> 1;
                        end
                    end else if (!acc_man[M]) begin
                        if (acc_exp <= EXP_ONE) begin
                            acc_zero <= 1'b1;
                            acc_sign <= 1'b0;
                            acc_exp  <= '0;
                            acc_man  <= '0;
                        end else begin
                            acc_exp <= acc_exp - EXP_ONE;
                            acc_man <= acc_man << 1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        acc_zero <= 1'b1;
                        acc_sign <= 1'b0;
                        acc_exp  <= '0;
                        acc_man  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_sum_accumulator.sv
// Self-checking bench for fp_sum_accumulator: expected sums queue up as last terms
// are driven and are compared when the output handshake happens.
module tb_fp_sum_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;

    int          tests    = 0;
    int          failures = 0;
    logic [31:0] sb[$];

    fp_sum_accumulator #(.DATA_WIDTH(32), .M(23), .E(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Output handshake pops the oldest expected sum.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            check_output("sb_nonempty", {31'b0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) check_output("sum", out_data, sb.pop_front());
        end
    end

    task automatic apply_stimulus(input string tag, input logic [31:0] data, input logic last,
                                  input int exp_busy, input logic [31:0] exp_sum);
        int guard = 0;
        int busy  = 0;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        check_output({tag, "_ready"}, {31'b0, in_ready}, 32'd1);
        if (last) sb.push_back(exp_sum);
        in_valid = 1'b1;
        in_data  = data;
        in_last  = last;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        while (!(in_ready || out_valid) && busy < 100) begin
            @(posedge clk); #1;
            busy++;
        end
        check_output({tag, "_busy"}, 32'(busy), 32'(exp_busy));
    endtask

    task automatic drain(input string tag, input int hold, input logic [31:0] exp, input logic poke);
        int guard = 0;
        while (!out_valid && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        check_output({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
        if (poke) begin
            in_valid = 1'b1;
            in_data  = 32'h3F800000;
            in_last  = 1'b1;
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check_output({tag, "_hold_valid"}, {31'b0, out_valid}, 32'd1);
            check_output({tag, "_hold_ready"}, {31'b0, in_ready}, 32'd0);
            check_output({tag, "_hold_data"}, out_data, exp);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_output({tag, "_drop_valid"}, {31'b0, out_valid}, 32'd0);
        check_output({tag, "_rise_ready"}, {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_output("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check_output("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check_output("rst_out_data", out_data, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 1.0 + 2.0
        apply_stimulus("one", 32'h3F800000, 1'b0, 1, 32'h0);
        apply_stimulus("two", 32'h40000000, 1'b1, 3, 32'h40400000);
        drain("s1", 2, 32'h40400000, 1'b0);

        // 1.5 - 1.0 needs one left shift
        apply_stimulus("p15", 32'h3FC00000, 1'b0, 1, 32'h0);
        apply_stimulus("m10", 32'hBF800000, 1'b1, 4, 32'h3F000000);
        drain("s2", 0, 32'h3F000000, 1'b0);

        // exact cancellation
        apply_stimulus("c1", 32'h3F800000, 1'b0, 1, 32'h0);
        apply_stimulus("c2", 32'hBF800000, 1'b1, 3, 32'h00000000);
        drain("s3", 0, 32'h0, 1'b0);

        // tiny operand truncated away
        apply_stimulus("t1", 32'h3F800000, 1'b0, 1, 32'h0);
        apply_stimulus("t2", 32'h33800000, 1'b1, 3, 32'h3F800000);
        drain("s4", 0, 32'h3F800000, 1'b0);

        // zero terms interleaved
        apply_stimulus("z1", 32'h80000000, 1'b0, 1, 32'h0);
        apply_stimulus("z2", 32'h00000000, 1'b0, 1, 32'h0);
        apply_stimulus("z3", 32'h40400000, 1'b1, 1, 32'h40400000);
        drain("s5", 0, 32'h40400000, 1'b0);
        apply_stimulus("z4", 32'h40400000, 1'b0, 1, 32'h0);
        apply_stimulus("z5", 32'h80000000, 1'b1, 1, 32'h40400000);
        drain("s6", 0, 32'h40400000, 1'b0);

        // saturation and underflow flush
        apply_stimulus("sat1", 32'h7F7FFFFF, 1'b0, 1, 32'h0);
        apply_stimulus("sat2", 32'h7F7FFFFF, 1'b1, 3, 32'h7F7FFFFF);
        drain("s7", 0, 32'h7F7FFFFF, 1'b0);
        apply_stimulus("fl1", 32'h00C00000, 1'b0, 1, 32'h0);
        apply_stimulus("fl2", 32'h80800000, 1'b1, 3, 32'h00000000);
        drain("s8", 0, 32'h0, 1'b0);

        // backpressure with in_valid held, then a fresh sum
        apply_stimulus("bp1", 32'h40000000, 1'b0, 1, 32'h0);
        apply_stimulus("bp2", 32'h40000000, 1'b1, 3, 32'h40800000);
        drain("bp", 5, 32'h40800000, 1'b1);
        apply_stimulus("bp3", 32'h3F800000, 1'b1, 1, 32'h3F800000);
        drain("s9", 0, 32'h3F800000, 1'b0);

        // reset during NORM discards the partial sum
        apply_stimulus("r1", 32'h3FC00000, 1'b0, 1, 32'h0);
        in_valid = 1'b1;
        in_data  = 32'hBF800000;
        in_last  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_output("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
        check_output("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        check_output("mid_rst_out_data", out_data, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            check_output("post_rst_quiet", {31'b0, out_valid}, 32'd0);
        end
        apply_stimulus("r2", 32'h40000000, 1'b1, 1, 32'h40000000);
        drain("s10", 0, 32'h40000000, 1'b0);

        repeat (3) @(posedge clk);
        check_output("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
